// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - MIPS R-type funct codes (F_*)
//   - state_t: control FSM states (IDLE, MUL, DIV, DONE)
//   - is_multicycle / is_divide / is_signed_md: decode helpers for the
//     multiply/divide family
package alu_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_multicycle(input logic [5:0] con);
        return (con == F_MULT) || (con == F_MULTU) ||
               (con == F_DIV)  || (con == F_DIVU);
    endfunction

    function automatic logic is_divide(input logic [5:0] con);
        return (con == F_DIV) || (con == F_DIVU);
    endfunction

    function automatic logic is_signed_md(input logic [5:0] con);
        return (con == F_MULT) || (con == F_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned iterative multiplier / restoring divider.
// One shared 2*WIDTH accumulator, one bit per clock, WIDTH iterations.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start        : one-cycle pulse, latches a/b/is_div and begins iterating
//   is_div       : 1 = divide a by b, 0 = multiply a by b
//   a, b         : unsigned operands (magnitudes)
//   done         : high during the final iteration cycle; hi/lo are final
//                  from the following cycle until the next start
//   hi, lo       : product {hi,lo}, or remainder (hi) / quotient (lo)
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_q;
    logic               busy;
    logic               mode_div;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_ext;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;

    // Multiply: add b into the upper half when the LSB is set, then shift
    // right with the carry entering the top.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift {rem, quotient} left, trial-subtract b.
    // rem_ext < 2*b, so the W+1 bit difference cannot wrap and its MSB is
    // the borrow.
    assign rem_ext  = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_ext - {1'b0, b_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign rem_new  = div_ge ? div_diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
    assign div_next = {rem_new, acc[WIDTH-2:0], div_ge};

    assign done = busy && (count == CW'(WIDTH - 1));
    assign hi   = acc[2*WIDTH-1:WIDTH];
    assign lo   = acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc      <= '0;
            b_q      <= '0;
            busy     <= 1'b0;
            mode_div <= 1'b0;
            count    <= '0;
        end else if (start) begin
            acc      <= {{WIDTH{1'b0}}, a};
            b_q      <= b;
            busy     <= 1'b1;
            mode_div <= is_div;
            count    <= '0;
        end else if (busy) begin
            acc   <= mode_div ? div_next : mul_next;
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked MIPS R-type ALU with iterative multiply/divide and
// HI/LO registers.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   in_valid / in_ready   : operation handshake (in1, in2, shamt, con)
//   in1, in2              : operands rs, rt
//   shamt                 : immediate shift amount for SLL/SRL/SRA
//   con                   : funct code
//   out_valid / out_ready : result handshake
//   out, zero, ovf, err   : registered result and flags, valid with out_valid
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. out_valid, out and the flags stay unchanged until the result
// is taken; in_ready never depends on in_valid.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [SHW-1:0]   shamt,
    input  logic [5:0]       con,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    state_t             state;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               neg_lo_q;   // negate product / quotient in DONE
    logic               neg_hi_q;   // negate remainder in DONE
    logic               md_div_q;

    logic               accept;
    logic               start_iter;
    logic               op_div;
    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic               iter_done;
    logic [WIDTH-1:0]   iter_hi;
    logic [WIDTH-1:0]   iter_lo;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [SHW-1:0]     shv;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_err;
    logic               hilo_wr;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign op_div     = is_divide(con);
    assign op_signed  = is_signed_md(con);
    // Divide by zero is resolved in the single-cycle path.
    assign start_iter = accept && is_multicycle(con) && !(op_div && (in2 == '0));

    assign sign_a = op_signed && in1[WIDTH-1];
    assign sign_b = op_signed && in2[WIDTH-1];
    assign mag_a  = sign_a ? -in1 : in1;
    assign mag_b  = sign_b ? -in2 : in2;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_iter),
        .is_div  (op_div),
        .a       (mag_a),
        .b       (mag_b),
        .done    (iter_done),
        .hi      (iter_hi),
        .lo      (iter_lo)
    );

    assign sum  = in1 + in2;
    assign diff = in1 - in2;
    assign shv  = in1[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        hilo_wr = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (con)
            F_ADD: begin
                alu_res = sum;
                alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            F_ADDU: alu_res = sum;
            F_SUB: begin
                alu_res = diff;
                alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            F_SUBU: alu_res = diff;
            F_AND:  alu_res = in1 & in2;
            F_OR:   alu_res = in1 | in2;
            F_XOR:  alu_res = in1 ^ in2;
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            F_SLL:  alu_res = in2 << shamt;
            F_SRL:  alu_res = in2 >> shamt;
            F_SRA:  alu_res = $signed(in2) >>> shamt;
            F_SLLV: alu_res = in2 << shv;
            F_SRLV: alu_res = in2 >> shv;
            F_SRAV: alu_res = $signed(in2) >>> shv;
            F_MFHI: alu_res = hi_q;
            F_MFLO: alu_res = lo_q;
            F_MULT, F_MULTU: alu_res = '0;
            F_DIV, F_DIVU: begin
                if (in2 == '0) begin
                    alu_res = '1;
                    hilo_wr = 1'b1;
                    hi_d    = in1;
                    lo_d    = '1;
                end
            end
            default: alu_err = 1'b1;
        endcase
    end

    // Sign correction of the unsigned iteration result.
    assign prod_raw = {iter_hi, iter_lo};
    assign prod_fix = neg_lo_q ? -prod_raw : prod_raw;

    always_comb begin
        if (md_div_q) begin
            fix_lo = neg_lo_q ? -iter_lo : iter_lo;
            fix_hi = neg_hi_q ? -iter_hi : iter_hi;
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            md_div_q  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_iter) begin
                        state    <= op_div ? DIV : MUL;
                        md_div_q <= op_div;
                        neg_lo_q <= sign_a ^ sign_b;
                        // The remainder follows the dividend; a product
                        // is negated as a whole via neg_lo_q.
                        neg_hi_q <= sign_a;
                    end else if (accept) begin
                        out       <= alu_res;
                        zero      <= (alu_res == '0);
                        ovf       <= alu_ovf;
                        err       <= alu_err;
                        out_valid <= 1'b1;
                        if (hilo_wr) begin
                            hi_q <= hi_d;
                            lo_q <= lo_d;
                        end
                    end
                end
                MUL, DIV: begin
                    if (iter_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi_q      <= fix_hi;
                    lo_q      <= fix_lo;
                    out       <= fix_lo;
                    zero      <= (fix_lo == '0);
                    ovf       <= 1'b0;
                    err       <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
